pin_input_conditioner: RTL and testbench
========================================

Name: pin_input_conditioner

Overview:
- Upstream front end for the microprocessor's 4-bit `i_pins` input.
- Synchronises four asynchronous external pins into `clk` with a 2-flop chain per pin, then debounces each pin independently.
- Drives clean, glitch-free levels (`clean_pins`) that feed the processor's `i_pins` input directly.
- Also captures sticky rising-edge flags that software or the top level can poll and acknowledge.

Parameters:
- DB_COUNT, 4: consecutive synchronised samples a new level must hold before it is accepted. Legal range 2..(2^CNT_W).
- CNT_W, 4: width of each per-pin debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- raw_pins  input  4  external, asynchronous pin levels.
- edge_ack  input  4  per-pin clear mask for `edge_flags`; each bit is sampled every cycle.
- clean_pins  output  4  debounced levels; connect to the processor's `i_pins`.
- edge_flags  output  4  sticky per-pin rising-edge flags.
- change_strobe  output  1  one-cycle pulse whenever any `clean_pins` bit changes.

Behaviour:
- Reset:
  - All state clears immediately: sync stages s1/s2, `clean_pins`, counters, `edge_flags` and `change_strobe` all go to 0.
  - Reset asserted mid-debounce discards the partial count. No stale flag survives reset.
- Synchroniser, per pin i:
  - s1[i] <= raw_pins[i]; s2[i] <= s1[i].
  - Only s2 feeds the debounce logic.
- Debounce, per pin i, evaluated every edge:
  - If s2[i] == clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_COUNT-1: clean[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Acceptance rule:
  - A raw level present for N >= DB_COUNT consecutive clock samples is accepted.
  - If the first new sample is taken at edge 0, `clean_pins` changes at edge DB_COUNT+1. With the default, that is edge 5.
  - N < DB_COUNT is rejected: `clean_pins` is unchanged, and the counter returns to 0 once s2 matches `clean_pins` again.
- Bounce handling:
  - A bounce back to the old level before acceptance restarts the count from 0.
  - Counts never accumulate across bounces.
- Independence: pins are fully independent. Simultaneous transitions on several pins are accepted on the same edge when their timing is identical.
- Edge flags, per pin:
  - Set: on the edge where clean[i] goes 0->1, edge_flags[i] <= 1.
  - Clear: edge_ack[i]=1 on an edge clears edge_flags[i].
  - Set and ack on the same edge: set wins, so the flag stays 1.
  - Ack of an already-clear flag has no effect.
  - Falling transitions do not touch the flags.
- change_strobe:
  - Registered; high for exactly the one cycle following any edge on which at least one clean bit changed.
  - Stays high in that cycle regardless of how many pins changed.
  - Back-to-back changes on consecutive edges give consecutive high cycles.
- Counter width: the counter never exceeds DB_COUNT-1, so no wrap-around is possible for legal parameter values.
- Latency summary: raw to clean is DB_COUNT+1 edges; clean to edge_flags/change_strobe is 0 edges (same edge as clean).

Test Plan:
1. Reset while raw_pins=4'b1111 -> all outputs 0. Deassert reset; edge 0 is the first raw sample -> clean_pins=4'b1111, edge_flags=4'b1111, change_strobe=1 at edge 5; change_strobe=0 from edge 6.
2. From clean_pins=0, pulse raw_pins[0] high for 3 cycles -> clean_pins stays 0, no flag, no strobe. Repeat the pulse for 4 cycles -> clean_pins[0]=1 at edge 5 after the first sample.
3. raw_pins[2] bounces 1,0,1,1,0,1,1,1,1 (one sample per cycle) -> accepted only after the final run of 4 ones; clean_pins[2] rises exactly DB_COUNT+1 edges after the start of that run, never earlier.
4. edge_flags[1]=1; assert edge_ack=4'b0010 for one cycle -> flag 0 on the next edge; other flags unchanged. Time edge_ack[1] to coincide with a new clean 0->1 on pin 1 -> flag stays 1.
5. clean_pins=4'b1010 and raw goes to 4'b0101 simultaneously -> all four bits change on one edge; change_strobe high for one cycle; edge_flags gains bits 0 and 2 only.
6. Assert reset for one cycle halfway through a debounce count, keeping raw steady high -> clean_pins goes 0 immediately, then acceptance restarts and completes DB_COUNT+1 edges after reset deasserts.

Source files
------------

// File: rtl/pin_input_conditioner.sv
// pin_input_conditioner
// Front end for the processor's 4-bit i_pins input. Each external pin is
// brought into the clk domain through a two-flop synchroniser and then
// debounced on its own counter. A new level is accepted only after it has
// been seen for DB_COUNT consecutive synchronised samples. Rising edges of
// the debounced levels set sticky flags that the consumer acknowledges.
// A registered strobe marks every cycle after a debounced level change.

module pin_input_conditioner #(
    parameter int DB_COUNT = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_pins,
    input  logic [3:0] edge_ack,
    output logic [3:0] clean_pins,
    output logic [3:0] edge_flags,
    output logic       change_strobe
);

    // Terminal count: a differing level is accepted on the edge where the
    // counter already holds DB_COUNT-1, so the counter never reaches
    // DB_COUNT and cannot wrap for any legal parameter choice.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchroniser stages.
    logic [3:0]       s1_q, s1_d;
    logic [3:0]       s2_q, s2_d;

    // Debounce state.
    logic [3:0]       clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Edge reporting.
    logic [3:0]       flags_q, flags_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       rise;

    // Two-flop synchroniser: s1 samples the asynchronous pins, s2 is the
    // only stage the debounce logic is allowed to look at.
    always_comb begin
        s1_d = raw_pins;
        s2_d = s1_q;
    end

    // Per-pin debounce: hold the counter at zero while the synchronised
    // level agrees with the accepted level, otherwise count up and accept
    // the new level on the terminal count. Any bounce back clears the count.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                clean_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Sticky rising-edge flags: acknowledge clears, but a rise on the same
    // edge wins over the acknowledge. Falling edges leave the flags alone.
    always_comb begin
        rise    = clean_d & ~clean_q;
        flags_d = (flags_q & ~edge_ack) | rise;
    end

    // Change strobe: one registered pulse per edge on which any debounced
    // bit changed, regardless of how many bits changed together.
    always_comb begin
        strobe_d = |(clean_d ^ clean_q);
    end

    // Synchroniser registers; reset clears both stages so no pre-reset pin
    // history leaks into the first post-reset debounce decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Debounce registers; reset discards any partial count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q <= clean_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flag and strobe registers; reset guarantees no stale flag survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            strobe_q <= strobe_d;
        end
    end

    assign clean_pins    = clean_q;
    assign edge_flags    = flags_q;
    assign change_strobe = strobe_q;

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed testbench for pin_input_conditioner with the default
// DB_COUNT=4: a new raw level sampled first at edge 0 appears on
// clean_pins at edge 5.

module tb_pin_input_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] raw_pins;
    logic [3:0] edge_ack;
    logic [3:0] clean_pins;
    logic [3:0] edge_flags;
    logic       change_strobe;

    int compared   = 0;
    int mismatched = 0;

    pin_input_conditioner #(
        .DB_COUNT (4),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_pins      (raw_pins),
        .edge_ack      (edge_ack),
        .clean_pins    (clean_pins),
        .edge_flags    (edge_flags),
        .change_strobe (change_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] f, input logic s);
        check({tag, "_clean"},  clean_pins,           c);
        check({tag, "_flags"},  edge_flags,           f);
        check({tag, "_strobe"}, {3'b000, change_strobe}, {3'b000, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seq [9];
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // ---- 1: reset with all pins high, then acceptance at edge 5 ----
        reset    = 1'b1;
        raw_pins = 4'b1111;
        edge_ack = 4'b0000;
        ticks(3);
        check_all("t1_reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        ticks(5);                              // edges 0..4
        check_all("t1_edge4", 4'b0000, 4'b0000, 1'b0);
        tick();                                // edge 5
        check_all("t1_edge5", 4'b1111, 4'b1111, 1'b1);
        tick();                                // edge 6
        check_all("t1_edge6", 4'b1111, 4'b1111, 1'b0);

        // Clear flags and bring everything back to zero.
        edge_ack = 4'b1111;
        tick();
        edge_ack = 4'b0000;
        check("t1_ack_all", edge_flags, 4'b0000);
        raw_pins = 4'b0000;
        ticks(5);
        check("t1_fall_edge4", clean_pins, 4'b1111);
        tick();
        check_all("t1_fall_edge5", 4'b0000, 4'b0000, 1'b1);
        ticks(2);

        // ---- 2: 3-cycle pulse rejected, 4-cycle pulse accepted ----
        raw_pins = 4'b0001;
        ticks(3);                              // edges 0..2 sample high
        raw_pins = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_all("t2_short", 4'b0000, 4'b0000, 1'b0);
        end
        raw_pins = 4'b0001;
        ticks(4);                              // edges 0..3 sample high
        raw_pins = 4'b0000;
        tick();                                // edge 4
        check("t2_long_edge4", clean_pins, 4'b0000);
        tick();                                // edge 5
        check_all("t2_long_edge5", 4'b0001, 4'b0001, 1'b1);
        ticks(3);                              // edges 6..8
        check("t2_hold_edge8", clean_pins, 4'b0001);
        tick();                                // edge 9: low from edge 4 accepted
        check_all("t2_fall_edge9", 4'b0000, 4'b0001, 1'b1);
        edge_ack = 4'b0001;
        tick();
        edge_ack = 4'b0000;
        check_all("t2_ack", 4'b0000, 4'b0000, 1'b0);

        // ---- 3: bouncing pin 2, accepted 5 edges after final run starts ----
        for (int k = 0; k < 10; k++) begin
            if (k < 9) raw_pins[2] = seq[k];
            tick();                            // edge k
            check("t3_bounce_hold", clean_pins, 4'b0000);
        end
        tick();                                // edge 10 = run start (5) + 5
        check_all("t3_accept", 4'b0100, 4'b0100, 1'b1);

        // ---- 4: acknowledge, and acknowledge colliding with a rise ----
        raw_pins = 4'b0110;
        ticks(6);
        check_all("t4_pin1_up", 4'b0110, 4'b0110, 1'b1);
        edge_ack = 4'b0010;
        tick();
        edge_ack = 4'b0000;
        check("t4_ack1", edge_flags, 4'b0100);
        raw_pins = 4'b0100;
        ticks(6);
        check_all("t4_pin1_down", 4'b0100, 4'b0100, 1'b1);
        raw_pins = 4'b0110;
        ticks(5);                              // edges 0..4
        edge_ack = 4'b0010;
        tick();                                // edge 5: rise and ack together
        edge_ack = 4'b0000;
        check_all("t4_set_wins", 4'b0110, 4'b0110, 1'b1);
        edge_ack = 4'b1000;                    // ack a flag that is already clear
        tick();
        edge_ack = 4'b0000;
        check_all("t4_ack_clear", 4'b0110, 4'b0110, 1'b0);

        // ---- 5: all four pins change together ----
        raw_pins = 4'b1010;
        ticks(6);
        check_all("t5_setup", 4'b1010, 4'b1110, 1'b1);
        edge_ack = 4'b1111;
        tick();
        edge_ack = 4'b0000;
        check("t5_ack", edge_flags, 4'b0000);
        raw_pins = 4'b0101;
        ticks(5);
        check_all("t5_edge4", 4'b1010, 4'b0000, 1'b0);
        tick();
        check_all("t5_edge5", 4'b0101, 4'b0101, 1'b1);
        tick();
        check("t5_strobe_one", {3'b000, change_strobe}, 4'b0000);

        // Back-to-back changes give consecutive strobe cycles.
        raw_pins = 4'b0100;                    // pin 0 falls, first sample edge 0
        tick();
        raw_pins = 4'b0110;                    // pin 1 rises, first sample edge 1
        ticks(5);                              // edges 1..5
        check_all("t5_b2b_first", 4'b0100, 4'b0101, 1'b1);
        tick();                                // edge 6
        check_all("t5_b2b_second", 4'b0110, 4'b0111, 1'b1);
        tick();
        check("t5_b2b_end", {3'b000, change_strobe}, 4'b0000);

        // ---- 6: reset in the middle of a debounce with raw held high ----
        raw_pins = 4'b1111;
        ticks(3);                              // pins 0 and 3 partly counted
        reset = 1'b1;
        #1;
        check_all("t6_async", 4'b0000, 4'b0000, 1'b0);
        tick();
        reset = 1'b0;
        ticks(5);                              // edges 0..4 after release
        check_all("t6_edge4", 4'b0000, 4'b0000, 1'b0);
        tick();                                // edge 5
        check_all("t6_edge5", 4'b1111, 4'b1111, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
